// File: rtl/lcd_text_sequencer_if.sv
// lcd_text_sequencer_if
// Purpose: bundles the write handshake between the text sequencer and the
//          4-bit LCD character driver.
// Signals:
//   lcd_write        sequencer -> driver  write_Enabled strobe
//   lcd_data         sequencer -> driver  iData character byte
//   lcd_ready        driver -> sequencer  driver idle / accepting
//   lcd_initialized  driver -> sequencer  oIsInitialized
// Modports: master = sequencer side, slave = driver side.
interface lcd_text_sequencer_if;
  logic       lcd_write;
  logic [7:0] lcd_data;
  logic       lcd_ready;
  logic       lcd_initialized;

  modport master (
    output lcd_write,
    output lcd_data,
    input  lcd_ready,
    input  lcd_initialized
  );

  modport slave (
    input  lcd_write,
    input  lcd_data,
    output lcd_ready,
    output lcd_initialized
  );
endinterface

// File: rtl/lcd_text_sequencer.sv
// lcd_text_sequencer
// Purpose: streams a message held in an internal character buffer into the
//          LCD character driver, one byte per driver write transaction, with
//          optional periodic auto-refresh.
// Ports:
//   Clock, Reset       system clock, synchronous active-high reset
//   buf_we/addr/wdata  character buffer write port (address taken mod DEPTH)
//   start, len         one-cycle send request and message length
//   auto_refresh       resend the last message after REFRESH_CYCLES idle
//   lcd                driver handshake (master modport)
//   busy, done         pass in progress / one-cycle end-of-pass pulse
//   error              sticky accept-timeout flag
//   char_index         index of the character currently being sent
module lcd_text_sequencer #(
  parameter int DEPTH          = 32,
  parameter int ACCEPT_TIMEOUT = 16,
  parameter int REFRESH_CYCLES = 2500000
) (
  input  logic                        Clock,
  input  logic                        Reset,
  input  logic                        buf_we,
  input  logic [4:0]                  buf_addr,
  input  logic [7:0]                  buf_wdata,
  input  logic                        start,
  input  logic [5:0]                  len,
  input  logic                        auto_refresh,
  lcd_text_sequencer_if.master        lcd,
  output logic                        busy,
  output logic                        done,
  output logic                        error,
  output logic [4:0]                  char_index
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int TW = $clog2(ACCEPT_TIMEOUT + 1);
  localparam int RW = $clog2(REFRESH_CYCLES + 1);
  localparam logic [5:0]    MAX_LEN      = 6'(DEPTH);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(ACCEPT_TIMEOUT - 1);
  localparam logic [RW-1:0] REFRESH_LAST = RW'(REFRESH_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_INIT,
    ISSUE,
    STROBE,
    WAIT_ACCEPT,
    WAIT_DONE,
    FINISH
  } state_t;

  state_t        state, state_next;
  logic [7:0]    mem [DEPTH];
  logic [7:0]    rd_data;
  logic [4:0]    index_next;
  logic [5:0]    len_q, len_next;
  logic [TW-1:0] tcnt, tcnt_next;
  logic [RW-1:0] rcnt, rcnt_next;
  logic          error_next;
  logic [7:0]    data_q, data_next;
  logic          write_q;
  logic          last_char;
  logic          refresh_expire;

  // Buffer is never cleared; writes land in any state so a host can
  // update characters that have not been sent yet in the current pass.
  always_ff @(posedge Clock) begin
    if (buf_we) mem[buf_addr[AW-1:0]] <= buf_wdata;
  end

  assign rd_data   = mem[char_index[AW-1:0]];
  assign last_char = ({1'b0, char_index} == (len_q - 6'd1));

  // A refresh with a zero remembered length would only produce a bare done
  // pulse, so it is suppressed entirely.
  assign refresh_expire = auto_refresh && (rcnt == REFRESH_LAST) && (len_q != 6'd0);

  // State and datapath registers. Outputs are registered from the next
  // state so lcd_write/lcd_data are clean flop outputs for the driver.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state      <= IDLE;
      char_index <= '0;
      len_q      <= '0;
      tcnt       <= '0;
      rcnt       <= '0;
      error      <= 1'b0;
      data_q     <= '0;
      write_q    <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= state_next;
      char_index <= index_next;
      len_q      <= len_next;
      tcnt       <= tcnt_next;
      rcnt       <= rcnt_next;
      error      <= error_next;
      data_q     <= data_next;
      write_q    <= (state_next == STROBE);
      busy       <= (state_next != IDLE);
      done       <= (state_next == FINISH);
    end
  end

  // Next-state and datapath logic. data_next is non-zero only on the
  // ISSUE->STROBE transition, which keeps lcd_data at 0 outside the strobe
  // and samples the buffer at the moment the strobe is entered.
  always_comb begin
    state_next = state;
    index_next = char_index;
    len_next   = len_q;
    tcnt_next  = tcnt;
    rcnt_next  = '0;
    error_next = error;
    data_next  = '0;
    case (state)
      IDLE: begin
        if (auto_refresh) begin
          rcnt_next = (rcnt == REFRESH_LAST) ? '0 : rcnt + 1'b1;
        end
        if (start) begin
          error_next = 1'b0;
          len_next   = (len > MAX_LEN) ? MAX_LEN : len;
          index_next = '0;
          rcnt_next  = '0;
          state_next = (len == 6'd0) ? FINISH : WAIT_INIT;
        end else if (refresh_expire) begin
          index_next = '0;
          rcnt_next  = '0;
          state_next = WAIT_INIT;
        end
      end
      WAIT_INIT: begin
        if (lcd.lcd_initialized) state_next = ISSUE;
      end
      ISSUE: begin
        if (lcd.lcd_ready) begin
          state_next = STROBE;
          data_next  = rd_data;
        end
      end
      STROBE: begin
        tcnt_next  = '0;
        state_next = WAIT_ACCEPT;
      end
      WAIT_ACCEPT: begin
        if (!lcd.lcd_ready) begin
          state_next = WAIT_DONE;
        end else if (tcnt == TIMEOUT_LAST) begin
          error_next = 1'b1;
          state_next = FINISH;
        end else begin
          tcnt_next = tcnt + 1'b1;
        end
      end
      WAIT_DONE: begin
        if (lcd.lcd_ready) begin
          if (last_char) begin
            state_next = FINISH;
          end else begin
            index_next = char_index + 5'd1;
            state_next = ISSUE;
          end
        end
      end
      FINISH: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign lcd.lcd_write = write_q;
  assign lcd.lcd_data  = data_q;

endmodule

// File: doc/lcd_text_sequencer.md
Name: lcd_text_sequencer

Overview:
- Streams a message from an internal character buffer into the 4-bit LCD character driver, one byte per driver write transaction.
- Sits between host logic (buffer writes, start/refresh control) and the LCD driver's write_Enabled / iData / ready / oIsInitialized interface.
- Owns all driver handshaking, so host logic only loads characters and pulses start.
- Optional auto-refresh re-sends the message periodically.

Parameters:
- DEPTH, 32, character buffer entries; power of two, at most 32.
- ACCEPT_TIMEOUT, 16, cycles allowed for driver ready to fall after a strobe before an error is flagged.
- REFRESH_CYCLES, 2500000, idle gap between auto-refresh passes (50 ms at 50 MHz).

Ports:
- Clock  in  1  system clock.
- Reset  in  1  synchronous, active-high.
- buf_we  in  1  character buffer write enable.
- buf_addr  in  5  buffer write address.
- buf_wdata  in  8  character to store.
- start  in  1  single-cycle request to send len characters.
- len  in  6  message length, sampled on accepted start.
- auto_refresh  in  1  restart automatically after REFRESH_CYCLES of idle.
- lcd_ready  in  1  driver ready.
- lcd_initialized  in  1  driver oIsInitialized.
- lcd_write  out  1  driver write_Enabled.
- lcd_data  out  8  driver iData.
- busy  out  1  transfer in progress.
- done  out  1  one-cycle pulse at end of pass.
- error  out  1  sticky accept-timeout flag.
- char_index  out  5  index of the current character.

Behaviour:
- Clock and reset: Clock, Reset synchronous active-high. All state is updated only on posedge Clock.
- Reset values: all outputs 0, FSM in IDLE, latched length 0, refresh counter 0. Buffer contents are undefined; the buffer is not cleared.
- Reset mid-transfer: abandons the pass with no done pulse. lcd_write is low from the first cycle after reset.
- Buffer writes: on buf_we, write buf_wdata to buf_addr mod DEPTH. Writes are accepted in every state. A byte is read when its STROBE is entered, so writes to not-yet-sent indices take effect in the current pass.
- start acceptance: accepted only in IDLE; ignored while busy.
- Length rules: latched length = min(len, DEPTH). A length of 0 gives a done pulse on the next cycle with no strobes.
- IDLE: busy=0.
  - On accepted start, or on auto-refresh expiry, go to WAIT_INIT; set char_index=0 and busy=1.
- Refresh counter: increments in IDLE while auto_refresh=1. It clears on leaving IDLE, and when auto_refresh=0.
  - Expiry is at REFRESH_CYCLES-1. Expiry reuses the last latched length; if that length is 0, there is no refresh.
- WAIT_INIT: hold until lcd_initialized=1, then go to ISSUE.
- ISSUE: when lcd_ready=1, go to STROBE.
- STROBE: exactly one cycle.
  - lcd_write=1 and lcd_data=buf[char_index], both registered and stable for that cycle.
  - Go to WAIT_ACCEPT.
- WAIT_ACCEPT: wait for lcd_ready=0.
  - If ready falls, go to WAIT_DONE.
  - After ACCEPT_TIMEOUT cycles with ready still high, set error=1 and go to FINISH.
- WAIT_DONE: wait for lcd_ready=1.
  - If char_index == length-1, go to FINISH.
  - Otherwise increment char_index and go to ISSUE.
- FINISH: one cycle with done=1, then IDLE with busy=0.
- lcd_write: never high in two consecutive cycles. Never high unless lcd_ready was 1 in the previous cycle.
- lcd_data: 0 whenever lcd_write=0.
- error: cleared only by Reset or by the next accepted start.
- Simultaneous start and auto-refresh expiry: start wins and uses the new len.

Test Plan:
- Load buf[0..3]="TEST" (0x54,0x45,0x53,0x54); start with len=4; driver model holds ready low for 100 cycles per byte -> exactly 4 one-cycle lcd_write pulses, data 0x54,0x45,0x53,0x54 in order, then one done pulse, busy low after it.
- Hold lcd_initialized=0 for 500 cycles, then pulse start -> no lcd_write until the cycle after initialized rises plus ISSUE/STROBE; busy=1 throughout.
- start with len=0 -> done pulse one cycle later, zero lcd_write pulses. start with len=40 -> exactly 32 writes.
- Driver model never drops ready -> error=1 after 16 cycles, single done pulse; next start clears error.
- auto_refresh=1, REFRESH_CYCLES=1000, len=2 -> second pass begins 1000 cycles after done; a start pulsed during a pass is ignored (write count unchanged).
- Assert Reset while in WAIT_DONE at char 5 -> next cycle all outputs 0; following start sends from index 0.
